// File: rtl/misao_pkg.sv
// misao_pkg: shared constants and types for the MISA-O front-end and decoder.
//   NIB_W / BYTE_W   instruction nibble and memory byte widths
//   PKG_ADDR_W       default byte address width of the memory bus
//   nib_addr_t       nibble address (byte address plus nibble select in bit 0)
//   OP_* / XOP_*     base and extended opcode nibble encodings
package misao_pkg;

  localparam int NIB_W      = 4;
  localparam int BYTE_W     = 8;
  localparam int PKG_ADDR_W = 15;

  typedef logic [PKG_ADDR_W:0] nib_addr_t;

  // Base opcodes, one nibble each
  localparam logic [NIB_W-1:0] OP_NOP  = 4'h0;
  localparam logic [NIB_W-1:0] OP_LDI  = 4'h1;
  localparam logic [NIB_W-1:0] OP_ADD  = 4'h2;
  localparam logic [NIB_W-1:0] OP_SUB  = 4'h3;
  localparam logic [NIB_W-1:0] OP_AND  = 4'h4;
  localparam logic [NIB_W-1:0] OP_OR   = 4'h5;
  localparam logic [NIB_W-1:0] OP_XOR  = 4'h6;
  localparam logic [NIB_W-1:0] OP_SHR  = 4'h7;
  localparam logic [NIB_W-1:0] OP_LD   = 4'h8;
  localparam logic [NIB_W-1:0] OP_ST   = 4'h9;
  localparam logic [NIB_W-1:0] OP_BEQZ = 4'hA;
  localparam logic [NIB_W-1:0] OP_BC   = 4'hB;
  localparam logic [NIB_W-1:0] OP_JAL  = 4'hC;
  localparam logic [NIB_W-1:0] OP_JMP  = 4'hD;
  localparam logic [NIB_W-1:0] OP_SWI  = 4'hE;
  localparam logic [NIB_W-1:0] OP_XOP  = 4'hF;

  // Extended opcodes, second nibble after OP_XOP
  localparam logic [NIB_W-1:0] XOP_RETI = 4'h0;
  localparam logic [NIB_W-1:0] XOP_XLD  = 4'h1;
  localparam logic [NIB_W-1:0] XOP_XST  = 4'h2;
  localparam logic [NIB_W-1:0] XOP_SEI  = 4'h3;
  localparam logic [NIB_W-1:0] XOP_CLI  = 4'h4;

endpackage

// File: rtl/misao_nib_fifo.sv
// misao_nib_fifo: synchronous FIFO taking 0, 1 or 2 entries per cycle and
// releasing at most one per cycle.
//   clk, rst       clock, synchronous active-low reset
//   i_flush        drop all contents (wins over push and pop)
//   i_push_cnt     number of entries written this cycle (0..2)
//   i_push_d0/d1   first / second entry written
//   i_pop          remove the head entry (caller guarantees non-empty)
//   o_head         current head entry
//   o_count        occupancy
module misao_nib_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic [1:0]       i_push_cnt,
  input  logic [W-1:0]     i_push_d0,
  input  logic [W-1:0]     i_push_d1,
  input  logic             i_pop,
  output logic [W-1:0]     o_head,
  output logic [CNT_W-1:0] o_count
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] w_wp1;

  assign w_wp1 = r_wp + 1'b1;

  // Pointer arithmetic is modular, so a two-entry advance wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + PTR_W'(i_push_cnt);
      r_rp  <= r_rp + PTR_W'(i_pop);
      r_cnt <= r_cnt + CNT_W'(i_push_cnt) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push_cnt != 2'd0) r_mem[r_wp]  <= i_push_d0;
    if (i_push_cnt == 2'd2) r_mem[w_wp1] <= i_push_d1;
  end

  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;

endmodule

// File: rtl/misao_nibble_fetch.sv
// misao_nibble_fetch: MISA-O instruction fetch front-end. Reads program
// bytes, splits them low nibble first, and hands nibbles to the decoder.
//   clk, rst         clock, synchronous active-low reset
//   bus_grant        fetch may use the memory bus this cycle
//   mem_enable_read  registered byte read strobe
//   mem_addr         registered byte address
//   mem_data_in      read data, MEM_LAT cycles after the read is issued
//   redirect_valid   load redirect_pc and flush buffered/in-flight nibbles
//   redirect_pc      new nibble address (bit 0 = nibble select)
//   nib_valid        a nibble is presented
//   nib_ready        decoder accepts the nibble when nib_valid is high
//   nib_data         instruction nibble
//   nib_pc           nibble address of nib_data
module misao_nibble_fetch
  import misao_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_grant,
  output logic              mem_enable_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [BYTE_W-1:0] mem_data_in,
  input  logic              redirect_valid,
  input  logic [ADDR_W:0]   redirect_pc,
  output logic              nib_valid,
  input  logic              nib_ready,
  output logic [NIB_W-1:0]  nib_data,
  output logic [ADDR_W:0]   nib_pc
);

  localparam int ENT_W = NIB_W + ADDR_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int CR_W  = CNT_W + LAT_W + 2;

  logic [ADDR_W:0]   r_fpc;
  logic              r_mem_en;
  logic [ADDR_W-1:0] r_mem_addr;

  logic              r_inf_vld_p  [MEM_LAT];
  logic              r_inf_odd_p  [MEM_LAT];
  logic [ADDR_W-1:0] r_inf_byte_p [MEM_LAT];

  logic [CNT_W-1:0]  w_occ;
  logic [LAT_W-1:0]  w_inflight;
  logic [CR_W-1:0]   w_need;
  logic              w_issue;
  logic              w_rsp_vld;
  logic              w_rsp_odd;
  logic [ADDR_W-1:0] w_rsp_byte;
  logic [1:0]        w_push_cnt;
  logic [ENT_W-1:0]  w_ent_lo;
  logic [ENT_W-1:0]  w_ent_hi;
  logic [ENT_W-1:0]  w_push_d0;
  logic [ENT_W-1:0]  w_head;
  logic              w_pop;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      w_inflight = w_inflight + LAT_W'(r_inf_vld_p[i]);
    end
  end

  // Every outstanding read is charged two FIFO slots, so the buffer cannot
  // overflow even if the decoder stops accepting nibbles for good.
  assign w_need  = CR_W'(w_occ) + (CR_W'(w_inflight) << 1) + CR_W'(2);
  assign w_issue = bus_grant && !redirect_valid && (w_need <= CR_W'(FIFO_DEPTH));

  // Issue stage: fetch PC and registered memory request
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fpc      <= '0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_mem_en <= w_issue;
      if (w_issue) r_mem_addr <= r_fpc[ADDR_W:1];
      if (redirect_valid) begin
        r_fpc <= redirect_pc;
      end else if (w_issue) begin
        // Always continue at the next even nibble, also after an odd redirect
        r_fpc <= {r_fpc[ADDR_W:1] + 1'b1, 1'b0};
      end
    end
  end

  assign mem_enable_read = r_mem_en;
  assign mem_addr        = r_mem_addr;

  // In-flight stages: one slot per outstanding read, aligned with the bus latency
  always_ff @(posedge clk) begin
    if (!rst || redirect_valid) begin
      for (int i = 0; i < MEM_LAT; i++) r_inf_vld_p[i] <= 1'b0;
    end else begin
      r_inf_vld_p[0] <= w_issue;
      for (int i = 1; i < MEM_LAT; i++) r_inf_vld_p[i] <= r_inf_vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_inf_odd_p[0]  <= r_fpc[0];
    r_inf_byte_p[0] <= r_fpc[ADDR_W:1];
    for (int i = 1; i < MEM_LAT; i++) begin
      r_inf_odd_p[i]  <= r_inf_odd_p[i-1];
      r_inf_byte_p[i] <= r_inf_byte_p[i-1];
    end
  end

  // Response stage: returning byte becomes one or two FIFO entries
  assign w_rsp_vld  = r_inf_vld_p[MEM_LAT-1];
  assign w_rsp_odd  = r_inf_odd_p[MEM_LAT-1];
  assign w_rsp_byte = r_inf_byte_p[MEM_LAT-1];

  assign w_ent_lo  = {mem_data_in[3:0], w_rsp_byte, 1'b0};
  assign w_ent_hi  = {mem_data_in[7:4], w_rsp_byte, 1'b1};
  assign w_push_d0 = w_rsp_odd ? w_ent_hi : w_ent_lo;

  always_comb begin
    w_push_cnt = 2'd0;
    if (w_rsp_vld) w_push_cnt = w_rsp_odd ? 2'd1 : 2'd2;
  end

  // A redirect flushes the buffer, so a pop in the same cycle is meaningless
  assign w_pop = nib_valid && nib_ready && !redirect_valid;

  misao_nib_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (redirect_valid),
    .i_push_cnt (w_push_cnt),
    .i_push_d0  (w_push_d0),
    .i_push_d1  (w_ent_hi),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_occ)
  );

  // Output stage: head shown combinationally, zeroed while the buffer is empty
  assign nib_valid = (w_occ != '0);
  assign nib_data  = nib_valid ? w_head[ENT_W-1 -: NIB_W] : '0;
  assign nib_pc    = nib_valid ? w_head[ADDR_W:0] : '0;

endmodule
